// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory controller: req/ack handshake with timeout, load/store lane formatting.
// Optional macro MISALIGN_TRAP_EN: misaligned accesses complete immediately with bus_err.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mem_read,
  input  logic [2:0]  mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busywait,
  output logic [31:0] load_data,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [29:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [29:0]      waddr_q, waddr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      load_q, load_d;
  logic             err_q, err_d;
  logic [1:0]       lo_q, lo_d;
  logic [2:0]       f3_q, f3_d;

  logic        is_read;
  logic        access;
  logic        misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  // A load takes precedence; a store issued together with it is dropped.
  assign is_read = mem_read[3];
  assign access  = mem_read[3] | mem_write[2];

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = 32'h0;
    if (!is_read) begin
      unique case (mem_write[1:0])
        2'b00: begin
          be_calc    = 4'b0001 << addr[1:0];
          wdata_calc = {4{store_data[7:0]}};
        end
        2'b01: begin
          be_calc    = 4'b0011 << {addr[1], 1'b0};
          wdata_calc = {2{store_data[15:0]}};
        end
        default: begin
          be_calc    = 4'b1111;
          wdata_calc = store_data;
        end
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    if (is_read) begin
      unique case (mem_read[2:0])
        3'b000, 3'b100: misaligned = 1'b0;
        3'b001, 3'b101: misaligned = addr[0];
        default:        misaligned = |addr[1:0];
      endcase
    end else begin
      unique case (mem_write[1:0])
        2'b00:   misaligned = 1'b0;
        2'b01:   misaligned = addr[0];
        default: misaligned = |addr[1:0];
      endcase
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                           input logic [1:0]  lo,
                                           input logic [31:0] rd);
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    logic [31:0] res;
    sh_b = rd >> {lo, 3'b000};
    sh_h = rd >> {lo[1], 4'b0000};
    case (f3)
      3'b000:  res = {{24{sh_b[7]}}, sh_b[7:0]};
      3'b001:  res = {{16{sh_h[15]}}, sh_h[15:0]};
      3'b100:  res = {24'h0, sh_b[7:0]};
      3'b101:  res = {16'h0, sh_h[15:0]};
      default: res = rd;
    endcase
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    waddr_d = waddr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    load_d  = load_q;
    err_d   = 1'b0;
    lo_d    = lo_q;
    f3_d    = f3_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            state_d = DONE;
            err_d   = 1'b1;
            load_d  = 32'h0;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            cnt_d   = '0;
            we_d    = ~is_read;
            waddr_d = addr[31:2];
            be_d    = be_calc;
            wdata_d = wdata_calc;
            lo_d    = addr[1:0];
            f3_d    = mem_read[2:0];
          end
        end
      end
      REQ: begin
        // An ack on the final allowed cycle still counts as success.
        if (dmem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) begin
            load_d = fmt_load(f3_q, lo_q, dmem_rdata);
          end
        end else if (cnt_q == CntMax) begin
          state_d = DONE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          load_d  = 32'h0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= 30'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      load_q  <= 32'h0;
      err_q   <= 1'b0;
      lo_q    <= 2'b00;
      f3_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
      f3_q    <= f3_d;
    end
  end

  // Gated by reset so the pipeline is never frozen while the controller is held in reset.
  assign busywait   = rst & access & (state_q != DONE);
  assign load_data  = load_q;
  assign bus_err    = err_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = waddr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl against a transaction-level reference model.
module tb_mem_access_ctrl;

  localparam int TO = 64;

  logic        clk;
  logic        rst;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busywait;
  logic [31:0] load_data;
  logic        bus_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [29:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  mem_access_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (7)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .store_data(store_data),
    .busywait  (busywait),
    .load_data (load_data),
    .bus_err   (bus_err),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_be   (dmem_be),
    .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .dmem_ack  (dmem_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_load = 32'h0;
  bit          in_done  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] b;
    logic [31:0] h;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic int access_bytes(input bit rd, input logic [2:0] f3, input logic [1:0] sz);
    logic [1:0] k;
    k = rd ? f3[1:0] : sz;
    if (k == 2'd0) return 1;
    if (k == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 4'(1 << (a % 4));
    if (sz == 2'd1) return 4'(3 << (2 * ((a / 2) % 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] sd);
    if (sz == 2'd0) return (sd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  // ack_at: REQ cycle (1-based) in which the memory acks; 0 means never.
  task automatic run_access(input bit rd, input logic [2:0] f3, input bit wr,
                            input logic [1:0] sz, input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rdata, input int ack_at);
    int  ncyc;
    bit  done;
    bit  trap;
    bit  acked;
    int  exp_cyc;
    bit  exp_err;
    mem_read   = {rd, f3};
    mem_write  = {wr, sz};
    addr       = a;
    store_data = sd;
    #1;
    if (in_done) begin
      check_eq("busywait_in_done", 32'(busywait), 32'd0);
      @(posedge clk); #1;
    end
`ifdef MISALIGN_TRAP_EN
    trap = (a % access_bytes(rd, f3, sz)) != 0;
`else
    trap = 1'b0;
`endif
    check_eq("idle_busywait", 32'(busywait), 32'd1);
    check_eq("idle_req", 32'(dmem_req), 32'd0);
    check_eq("idle_bus_err", 32'(bus_err), 32'd0);
    ncyc = 0;
    done = 1'b0;
    for (int c = 0; c < TO + 8; c++) begin
      @(posedge clk); #1;
      if (!busywait) begin
        done = 1'b1;
        break;
      end
      ncyc++;
      if (ncyc == 1) begin
        check_eq("req_we", 32'(dmem_we), 32'(!rd));
        check_eq("req_addr", 32'(dmem_addr), a >> 2);
        check_eq("req_be", 32'(dmem_be), 32'(rd ? 4'hF : ref_be(sz, a)));
        if (!rd) check_eq("req_wdata", dmem_wdata, ref_wdata(sz, sd));
      end
      check_eq("req_held", 32'(dmem_req), 32'd1);
      dmem_rdata = rdata;
      dmem_ack   = (ncyc == ack_at);
    end
    dmem_ack = 1'b0;
    check_eq("done_reached", 32'(done), 32'd1);
    if (!done) return;
    acked   = !trap && ack_at >= 1 && ack_at <= TO;
    exp_cyc = trap ? 0 : (acked ? ack_at : TO);
    exp_err = !acked;
    if (exp_err) exp_load = 32'h0;
    else if (rd) exp_load = ref_load(f3, a, rdata);
    check_eq("req_cycles", 32'(ncyc), 32'(exp_cyc));
    check_eq("done_bus_err", 32'(bus_err), 32'(exp_err));
    check_eq("done_load_data", load_data, exp_load);
    check_eq("done_req", 32'(dmem_req), 32'd0);
    in_done = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    mem_read  = 4'h0;
    mem_write = 3'h0;
    #1;
    for (int i = 0; i < n; i++) begin
      check_eq("idle_no_busy", 32'(busywait), 32'd0);
      @(posedge clk); #1;
      in_done = 1'b0;
    end
    check_eq("idle_load_hold", load_data, exp_load);
  endtask

  initial begin
    rst        = 1'b0;
    mem_read   = 4'h0;
    mem_write  = 3'h0;
    addr       = 32'h0;
    store_data = 32'h0;
    dmem_rdata = 32'h0;
    dmem_ack   = 1'b0;
    #2;
    check_eq("rst_req", 32'(dmem_req), 32'd0);
    check_eq("rst_addr", 32'(dmem_addr), 32'd0);
    check_eq("rst_be", 32'(dmem_be), 32'd0);
    check_eq("rst_wdata", dmem_wdata, 32'd0);
    check_eq("rst_load", load_data, 32'd0);
    check_eq("rst_busywait", 32'(busywait), 32'd0);
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    idle_cycles(2);

    // Reset in the middle of a pending request.
    mem_read  = 4'h0;
    mem_write = 3'b110;
    addr      = 32'h0000_0208;
    store_data = 32'h1234_5678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("mid_req_up", 32'(dmem_req), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_req", 32'(dmem_req), 32'd0);
    check_eq("mid_rst_we", 32'(dmem_we), 32'd0);
    check_eq("mid_rst_be", 32'(dmem_be), 32'd0);
    check_eq("mid_rst_addr", 32'(dmem_addr), 32'd0);
    check_eq("mid_rst_wdata", dmem_wdata, 32'd0);
    check_eq("mid_rst_busy", 32'(busywait), 32'd0);
    mem_write = 3'h0;
    #1;
    rst = 1'b1;
    exp_load = 32'h0;
    in_done  = 1'b0;
    @(posedge clk); #1;
    idle_cycles(1);

    // Directed cases.
    run_access(1'b0, 3'd0, 1'b1, 2'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 3);
    run_access(1'b0, 3'd0, 1'b1, 2'd0, 32'h0000_0103, 32'h0000_00A5, 32'h0, 1);
    run_access(1'b1, 3'd0, 1'b0, 2'd0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 2);
    check_eq("lb_sign", load_data, 32'hFFFF_FF80);
    run_access(1'b1, 3'd5, 1'b0, 2'd0, 32'h0000_0102, 32'h0, 32'hBEEF_1234, 1);
    check_eq("lhu_zero", load_data, 32'h0000_BEEF);
    run_access(1'b1, 3'd1, 1'b0, 2'd0, 32'h0000_0102, 32'h0, 32'hBEEF_1234, 4);
    check_eq("lh_sign", load_data, 32'hFFFF_BEEF);
    run_access(1'b1, 3'd1, 1'b1, 2'd2, 32'h0000_0300, 32'h5555_5555, 32'h0000_8001, 2);
    run_access(1'b1, 3'd2, 1'b0, 2'd0, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, TO);

    // Timeout, then an ack arriving too late must be ignored.
    run_access(1'b1, 3'd2, 1'b0, 2'd0, 32'h0000_0040, 32'h0, 32'h1111_1111, 0);
    mem_read   = 4'h0;
    mem_write  = 3'h0;
    dmem_rdata = 32'h7777_7777;
    dmem_ack   = 1'b1;
    @(posedge clk); #1;
    check_eq("late_ack_err", 32'(bus_err), 32'd0);
    check_eq("late_ack_req", 32'(dmem_req), 32'd0);
    check_eq("late_ack_load", load_data, 32'h0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check_eq("late_ack_req2", 32'(dmem_req), 32'd0);
    in_done = 1'b0;
    idle_cycles(1);

    run_access(1'b1, 3'd2, 1'b0, 2'd0, 32'h0000_0101, 32'h0, 32'h0BAD_CAFE, 2);
    run_access(1'b0, 3'd0, 1'b1, 2'd1, 32'h0000_0105, 32'h0000_ABCD, 32'h0, 1);

    // Random traffic, back-to-back or separated by idle cycles.
    for (int t = 0; t < 250; t++) begin
      bit          rd;
      bit          wr;
      int          r;
      int          ack_at;
      rd = bit'($urandom_range(0, 1));
      wr = rd ? bit'($urandom_range(0, 1)) : 1'b1;
      r  = int'($urandom_range(0, 9));
      ack_at = (r == 0) ? 0 : ((r == 1) ? TO : r - 1);
      run_access(rd, 3'($urandom_range(0, 7)), wr, 2'($urandom_range(0, 2)), $urandom,
                 $urandom, $urandom, ack_at);
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
